fetch_ctrl: RTL and testbench

Sequencer for the program-counter register and instruction-memory port in the RV32 fetch stage. Drives the PC register's `stall`/`sel`/`vect` controls. Issues one instruction-memory request at a time and presents fetched instructions to decode through a one-entry output register. Arbitrates PC redirects (trap over branch), flushes the stage, and discards stale in-flight responses.

---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/fetch_ctrl_if.sv | 40 ++++
 rtl/fetch_ctrl_redirect_arb.sv | 25 ++
 rtl/fetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the RV32 fetch-stage sequencer.
// Optional misalignment checking is compiled in with FETCH_MISALIGN_CHECK_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECT = 32'h0000_0000;
  localparam int unsigned INSTR_W            = 32;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer and its PC register, instruction
// memory, redirect sources and decode. master = fetch_ctrl side.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic [31:0]        pc;
  logic               trap_req;
  logic [31:0]        trap_vect;
  logic               br_req;
  logic [31:0]        br_target;
  logic               hz_stall;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               pc_stall;
  logic               pc_sel;
  logic [31:0]        pc_vect;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [31:0]        if_pc;
  logic               flush;
  logic               misalign_err;

  modport master (
    input  pc, trap_req, trap_vect, br_req, br_target, hz_stall,
           imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, pc_stall, pc_sel, pc_vect,
           if_valid, if_instr, if_pc, flush, misalign_err
  );

  modport slave (
    output pc, trap_req, trap_vect, br_req, br_target, hz_stall,
           imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, pc_stall, pc_sel, pc_vect,
           if_valid, if_instr, if_pc, flush, misalign_err
  );

endinterface

// File: rtl/fetch_ctrl_redirect_arb.sv
// Trap-over-branch redirect select; with FETCH_MISALIGN_CHECK_EN defined it
// also flags targets that are not word aligned.
module redirect_arb
  import fetch_pkg::*;
(
  input  logic        trap_req,
  input  logic [31:0] trap_vect,
  input  logic        br_req,
  input  logic [31:0] br_target,
  output logic        redir_valid,
  output logic [31:0] redir_target,
  output logic        redir_err
);

  always_comb begin
    redir_valid  = trap_req | br_req;
    redir_target = trap_req ? trap_vect : br_target;
`ifdef FETCH_MISALIGN_CHECK_EN
    redir_err    = redir_valid & is_misaligned(redir_target);
`else
    redir_err    = 1'b0;
`endif
  end

endmodule

// File: rtl/fetch_ctrl.sv
// RV32 fetch sequencer: PC register control, single-outstanding imem port,
// redirect/flush handling and one-entry output register (macro: FETCH_MISALIGN_CHECK_EN).
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECT = DEFAULT_RESET_VECT
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_ctrl_if.master bus
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic               r_if_valid;
  logic [INSTR_W-1:0] r_if_instr;
  logic [31:0]        r_if_pc;

  logic               w_redir_valid;
  logic [31:0]        w_redir_target;
  logic               w_redir_err;
  logic               w_redirect;
  logic               w_load;
  logic               w_imem_req;
  logic [31:0]        w_imem_addr;
  logic               w_pc_stall;
  logic               w_pc_sel;
  logic [31:0]        w_pc_vect;
  logic               w_flush;
  logic               w_misalign_err;

  redirect_arb u_redirect_arb (
    .trap_req     (bus.trap_req),
    .trap_vect    (bus.trap_vect),
    .br_req       (bus.br_req),
    .br_target    (bus.br_target),
    .redir_valid  (w_redir_valid),
    .redir_target (w_redir_target),
    .redir_err    (w_redir_err)
  );

  assign w_redirect = w_redir_valid & (r_state != ST_BOOT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_load         = 1'b0;
    w_imem_req     = 1'b0;
    w_imem_addr    = 32'h0;
    w_pc_stall     = 1'b1;
    w_pc_sel       = 1'b0;
    w_pc_vect      = 32'h0;
    w_flush        = 1'b0;
    w_misalign_err = 1'b0;

    case (r_state)
      ST_BOOT: begin
        // Outputs keep their reset values while reset is still asserted.
        if (reset_n) begin
          w_pc_sel     = 1'b1;
          w_pc_vect    = RESET_VECT;
          w_pc_stall   = 1'b0;
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        w_imem_req  = ~(r_if_valid & bus.hz_stall);
        w_imem_addr = bus.pc;
        if (w_imem_req && bus.imem_gnt) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.imem_rvalid) begin
          w_load       = 1'b1;
          w_pc_stall   = 1'b0;
          w_state_next = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (bus.imem_rvalid) begin
          w_state_next = ST_REQ;
        end
      end
      default: w_state_next = ST_BOOT;
    endcase

    if (w_redirect) begin
      w_flush    = 1'b1;
      w_imem_req = 1'b0;
      w_load     = 1'b0;
      if (w_redir_err) begin
        w_pc_stall     = 1'b1;
        w_pc_sel       = 1'b0;
        w_misalign_err = 1'b1;
      end else begin
        w_pc_stall = 1'b0;
        w_pc_sel   = 1'b1;
        w_pc_vect  = w_redir_target;
      end
      // A response still in flight must be swallowed before refetching.
      if ((r_state == ST_RESP || r_state == ST_DRAIN) && !bus.imem_rvalid) begin
        w_state_next = ST_DRAIN;
      end else begin
        w_state_next = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= 32'h0;
    end else if (w_redirect) begin
      r_if_valid <= 1'b0;
    end else if (w_load) begin
      r_if_valid <= 1'b1;
      r_if_instr <= bus.imem_rdata;
      r_if_pc    <= bus.pc;
    end else if (r_if_valid && !bus.hz_stall) begin
      r_if_valid <= 1'b0;
    end
  end

  assign bus.imem_req     = w_imem_req;
  assign bus.imem_addr    = w_imem_addr;
  assign bus.pc_stall     = w_pc_stall;
  assign bus.pc_sel       = w_pc_sel;
  assign bus.pc_vect      = w_pc_vect;
  assign bus.flush        = w_flush;
  assign bus.misalign_err = w_misalign_err;
  assign bus.if_valid     = r_if_valid;
  assign bus.if_instr     = r_if_instr;
  assign bus.if_pc        = r_if_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: PC register and instruction memory models,
// directed redirect/stall vectors, monitor comparing instructions handed to decode.
module tb_fetch_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   lat;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_VECT(32'h100)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.pc <= 32'h0;
    end else if (!bus.pc_stall) begin
      bus.pc <= bus.pc_sel ? bus.pc_vect : bus.pc + 32'd4;
    end
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a < 32'h200) return 32'h0000_0013;
    return (a << 12) | 32'h0000_0013;
  endfunction

  // Instruction memory: grants any request, answers after lat extra cycles.
  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    pend  = 1'b0;
    cnt   = 0;
    paddr = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      bus.imem_rvalid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_data(paddr);
          pend = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      bus.imem_gnt = bus.imem_req;
      @(negedge clk);
      if (bus.imem_req && bus.imem_gnt) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = bus.imem_addr;
      end
      if (!reset_n) pend = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every instruction decode accepts must match the next expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && bus.if_valid && !bus.hz_stall && !bus.flush) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_if: got pc=%h instr=%h expected nothing", bus.if_pc, bus.if_instr);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.if_pc !== mon_e.pc || bus.if_instr !== mon_e.instr) begin
            failures++;
            $display("FAIL if_out: got pc=%h instr=%h expected pc=%h instr=%h",
                     bus.if_pc, bus.if_instr, mon_e.pc, mon_e.instr);
          end else begin
            $display("accepted pc=%h instr=%h", bus.if_pc, bus.if_instr);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    lat       = 0;
    reset_n   = 1'b0;
    bus.trap_req  = 1'b0;
    bus.trap_vect = 32'h0;
    bus.br_req    = 1'b0;
    bus.br_target = 32'h0;
    bus.hz_stall  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_pc_stall", bus.pc_stall, 1);
    chk("rst_pc_sel", bus.pc_sel, 0);
    chk("rst_pc_vect", bus.pc_vect, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_if_instr", bus.if_instr, 0);
    chk("rst_if_pc", bus.if_pc, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_misalign", bus.misalign_err, 0);

    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("boot_pc_sel", bus.pc_sel, 1);
    chk("boot_pc_vect", bus.pc_vect, 32'h100);
    chk("boot_pc_stall", bus.pc_stall, 0);
    chk("boot_imem_req", bus.imem_req, 0);

    exp_q.push_back('{32'h100, 32'h13});
    exp_q.push_back('{32'h104, 32'h13});
    exp_q.push_back('{32'h108, 32'h13});

    step(); @(negedge clk);  // REQ 0x100
    chk("r1_imem_req", bus.imem_req, 1);
    chk("r1_imem_addr", bus.imem_addr, 32'h100);
    chk("r1_pc_stall", bus.pc_stall, 1);
    step(); @(negedge clk);  // RESP with data
    chk("r2_pc_stall", bus.pc_stall, 0);
    chk("r2_pc_sel", bus.pc_sel, 0);
    chk("r2_if_valid", bus.if_valid, 0);
    step(); @(negedge clk);
    chk("r3_if_valid", bus.if_valid, 1);
    chk("r3_imem_req", bus.imem_req, 1);
    chk("r3_imem_addr", bus.imem_addr, 32'h104);
    step(); @(negedge clk);
    chk("r4_if_valid", bus.if_valid, 0);
    step(); @(negedge clk);
    chk("r5_if_valid", bus.if_valid, 1);
    chk("r5_imem_addr", bus.imem_addr, 32'h108);
    step(); @(negedge clk);

    step(); bus.hz_stall = 1'b1; @(negedge clk);
    chk("stall_imem_req", bus.imem_req, 0);
    chk("stall_if_valid", bus.if_valid, 1);
    chk("stall_if_pc", bus.if_pc, 32'h108);
    step(); @(negedge clk);
    chk("stall2_imem_req", bus.imem_req, 0);
    chk("stall2_if_pc", bus.if_pc, 32'h108);
    chk("stall2_if_instr", bus.if_instr, 32'h13);
    step(); bus.hz_stall = 1'b0; lat = 3; @(negedge clk);
    chk("resume_imem_req", bus.imem_req, 1);
    chk("resume_imem_addr", bus.imem_addr, 32'h10C);

    step(); bus.br_req = 1'b1; bus.br_target = 32'h200; @(negedge clk);
    chk("br_flush", bus.flush, 1);
    chk("br_pc_sel", bus.pc_sel, 1);
    chk("br_pc_vect", bus.pc_vect, 32'h200);
    chk("br_pc_stall", bus.pc_stall, 0);
    chk("br_imem_req", bus.imem_req, 0);
    step(); bus.br_req = 1'b0; lat = 0; @(negedge clk);
    chk("drain_flush", bus.flush, 0);
    chk("drain_imem_req", bus.imem_req, 0);
    chk("drain_pc_stall", bus.pc_stall, 1);
    step(); @(negedge clk);
    chk("drain2_imem_req", bus.imem_req, 0);
    step(); @(negedge clk);  // stale response arrives
    chk("drain3_imem_req", bus.imem_req, 0);
    chk("drain3_pc_stall", bus.pc_stall, 1);
    step(); @(negedge clk);
    chk("refetch_imem_req", bus.imem_req, 1);
    chk("refetch_imem_addr", bus.imem_addr, 32'h200);
    chk("refetch_if_valid", bus.if_valid, 0);

    step();  // RESP with data and a simultaneous trap+branch
    bus.trap_req = 1'b1; bus.trap_vect = 32'h80;
    bus.br_req = 1'b1; bus.br_target = 32'h200;
    @(negedge clk);
    chk("prio_pc_vect", bus.pc_vect, 32'h80);
    chk("prio_pc_sel", bus.pc_sel, 1);
    chk("prio_flush", bus.flush, 1);
    step(); bus.trap_req = 1'b0; bus.br_req = 1'b0;
    exp_q.push_back('{32'h80, 32'h13});
    @(negedge clk);
    chk("trap_imem_req", bus.imem_req, 1);
    chk("trap_imem_addr", bus.imem_addr, 32'h80);
    chk("trap_if_valid", bus.if_valid, 0);
    step(); @(negedge clk);
    step(); @(negedge clk);
    chk("trap_out_if_pc", bus.if_pc, 32'h80);

    step(); bus.br_req = 1'b1; bus.br_target = 32'h202;
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_q.push_back('{32'h84, 32'h13});
`else
    exp_q.push_back('{32'h202, 32'h00202013});
`endif
    @(negedge clk);
    chk("mis_flush", bus.flush, 1);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_err", bus.misalign_err, 1);
    chk("mis_pc_sel", bus.pc_sel, 0);
    chk("mis_pc_stall", bus.pc_stall, 1);
`else
    chk("mis_err", bus.misalign_err, 0);
    chk("mis_pc_sel", bus.pc_sel, 1);
    chk("mis_pc_vect", bus.pc_vect, 32'h202);
`endif
    step(); bus.br_req = 1'b0; @(negedge clk);
    chk("mis_next_req", bus.imem_req, 1);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_next_addr", bus.imem_addr, 32'h84);
`else
    chk("mis_next_addr", bus.imem_addr, 32'h202);
`endif
    chk("mis_err_pulse", bus.misalign_err, 0);
    step(); @(negedge clk);
    step(); @(negedge clk);
    chk("mis_out_valid", bus.if_valid, 1);

    step(); reset_n = 1'b0; @(negedge clk);
    chk("midrst_imem_req", bus.imem_req, 0);
    chk("midrst_pc_stall", bus.pc_stall, 1);
    chk("midrst_pc_sel", bus.pc_sel, 0);
    chk("midrst_if_valid", bus.if_valid, 0);
    step(); reset_n = 1'b1; @(negedge clk);
    chk("reboot_pc_sel", bus.pc_sel, 1);
    chk("reboot_pc_vect", bus.pc_vect, 32'h100);
    step(); @(negedge clk);
    chk("reboot_imem_req", bus.imem_req, 1);
    chk("reboot_imem_addr", bus.imem_addr, 32'h100);

    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
